// File: rtl/udiv8_seq_if.sv
// Operand/result bundle for udiv8_seq; dz exists only when UDIV_DZ_FLAG_EN is defined.
// Buses are numbered MSB-first ([0:N]) to match the packed SIMD register layout.
interface udiv8_seq_if;
    logic         start;
    logic [0:1]   ctrl_ww;
    logic [0:127] reg_A;
    logic [0:127] reg_B;
    logic [0:127] result;
    logic         busy;
    logic         done;
    logic [0:7]   ovf;
`ifdef UDIV_DZ_FLAG_EN
    logic [0:7]   dz;

    modport master (output start, ctrl_ww, reg_A, reg_B,
                    input  result, busy, done, ovf, dz);
    modport slave  (input  start, ctrl_ww, reg_A, reg_B,
                    output result, busy, done, ovf, dz);
`else
    modport master (output start, ctrl_ww, reg_A, reg_B,
                    input  result, busy, done, ovf);
    modport slave  (input  start, ctrl_ww, reg_A, reg_B,
                    output result, busy, done, ovf);
`endif
endinterface

// File: rtl/udiv8_seq.sv
// Packed restoring divider: 8x(16/8) or 4x(32/16) lanes, one quotient bit per cycle, all lanes in parallel.
// Latency: done N cycles after the start edge (N = 8 or 16), 0 extra for an invalid mode; optional dz flags under UDIV_DZ_FLAG_EN.
// Backpressure: none; start is only honoured in IDLE, so the next op may begin the cycle after done.
module udiv8_seq (
    input  logic       clk,
    input  logic       rst_n,
    udiv8_seq_if.slave bus
);
    localparam logic [1:0] W8     = 2'd0;
    localparam logic [1:0] W16    = 2'd1;
    localparam logic [1:0] MODE8  = W8 + 2'd1;
    localparam logic [1:0] MODE16 = W16 + 2'd1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t       r_state, w_state_nxt;
    logic         r_mode16;
    logic [4:0]   r_cnt;
    logic [15:0]  r_rem [0:7];
    logic [15:0]  r_lo  [0:7];
    logic [15:0]  r_dvs [0:7];
    logic [14:0]  r_q   [0:7];
    logic [0:7]   r_lane_ovf;
    logic [0:127] r_result;
    logic [0:7]   r_ovf;

    logic         w_valid, w_mode16_in, w_last, w_unused_b;
    logic [15:0]  w_ld_rem [0:7];
    logic [15:0]  w_ld_lo  [0:7];
    logic [15:0]  w_ld_dvs [0:7];
    logic [0:7]   w_ld_ovf;
    logic [16:0]  w_shift   [0:7];
    logic [15:0]  w_rem_nxt [0:7];
    logic [15:0]  w_q_nxt   [0:7];
    logic [0:127] w_res;

    assign w_mode16_in = (bus.ctrl_ww == MODE16);
    assign w_valid     = (bus.ctrl_ww == MODE8) || w_mode16_in;
    assign w_last      = (r_state == CALC) && (r_cnt == 5'd1);

    // Operand unpack: upper half of D seeds the partial remainder, lower half is shifted in.
    always_comb begin
        w_unused_b = 1'b0;
        w_ld_ovf   = '0;
        for (int k = 0; k < 8; k++) begin
            w_ld_rem[k] = '0;
            w_ld_lo[k]  = '0;
            w_ld_dvs[k] = '0;
        end
        if (w_mode16_in) begin
            for (int j = 0; j < 4; j++) begin
                w_ld_rem[j] = bus.reg_A[32*j +: 16];
                w_ld_lo[j]  = bus.reg_A[32*j+16 +: 16];
                w_ld_dvs[j] = bus.reg_B[32*j +: 16];
                w_ld_ovf[j] = bus.reg_A[32*j +: 16] >= bus.reg_B[32*j +: 16];
            end
        end else if (w_valid) begin
            for (int k = 0; k < 8; k++) begin
                w_ld_rem[k] = {8'h00, bus.reg_A[16*k +: 8]};
                w_ld_lo[k]  = {8'h00, bus.reg_A[16*k+8 +: 8]};
                w_ld_dvs[k] = {8'h00, bus.reg_B[16*k +: 8]};
                w_ld_ovf[k] = bus.reg_A[16*k +: 8] >= bus.reg_B[16*k +: 8];
            end
        end
        for (int j = 0; j < 4; j++) begin
            w_unused_b = w_unused_b ^ (^bus.reg_B[32*j+24 +: 8]);
        end
    end

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_shift[k] = r_mode16 ? {r_rem[k], r_lo[k][15]}
                                  : {8'h00, r_rem[k][7:0], r_lo[k][7]};
            if (w_shift[k] >= {1'b0, r_dvs[k]}) begin
                w_rem_nxt[k] = 16'(w_shift[k] - {1'b0, r_dvs[k]});
                w_q_nxt[k]   = {r_q[k], 1'b1};
            end else begin
                w_rem_nxt[k] = w_shift[k][15:0];
                w_q_nxt[k]   = {r_q[k], 1'b0};
            end
        end
    end

    // Final-iteration values are packed directly so result lands on the same edge as the last step.
    always_comb begin
        w_res = '0;
        if (r_mode16) begin
            for (int j = 0; j < 4; j++) begin
                w_res[32*j +: 32] = r_lane_ovf[j] ? 32'hFFFF_FFFF : {w_q_nxt[j], w_rem_nxt[j]};
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                w_res[16*k +: 16] = r_lane_ovf[k] ? 16'hFFFF : {w_q_nxt[k][7:0], w_rem_nxt[k][7:0]};
            end
        end
    end

`ifdef UDIV_DZ_FLAG_EN
    logic [0:7] r_dz;
    logic [0:7] w_dz;

    always_comb begin
        w_dz = '0;
        for (int k = 0; k < 8; k++) begin
            w_dz[k] = (r_dvs[k] == 16'h0000) && (!r_mode16 || (k < 4));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dz <= '0;
        end else if (r_state == IDLE && bus.start && !w_valid) begin
            r_dz <= '0;
        end else if (w_last) begin
            r_dz <= w_dz;
        end
    end

    assign bus.dz = r_dz;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode16   <= 1'b0;
            r_cnt      <= '0;
            r_lane_ovf <= '0;
            r_result   <= '0;
            r_ovf      <= '0;
            for (int k = 0; k < 8; k++) begin
                r_rem[k] <= '0;
                r_lo[k]  <= '0;
                r_dvs[k] <= '0;
                r_q[k]   <= '0;
            end
        end else if (r_state == IDLE && bus.start) begin
            r_mode16   <= w_mode16_in;
            r_cnt      <= w_mode16_in ? 5'd16 : 5'd8;
            r_lane_ovf <= w_ld_ovf;
            for (int k = 0; k < 8; k++) begin
                r_rem[k] <= w_ld_rem[k];
                r_lo[k]  <= w_ld_lo[k];
                r_dvs[k] <= w_ld_dvs[k];
                r_q[k]   <= '0;
            end
            if (!w_valid) begin
                r_result <= '0;
                r_ovf    <= '0;
            end
        end else if (r_state == CALC) begin
            r_cnt <= r_cnt - 5'd1;
            for (int k = 0; k < 8; k++) begin
                r_rem[k] <= w_rem_nxt[k];
                r_lo[k]  <= {r_lo[k][14:0], 1'b0};
                r_q[k]   <= w_q_nxt[k][14:0];
            end
            if (w_last) begin
                r_result <= w_res;
                r_ovf    <= r_lane_ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = w_valid ? CALC : DONE;
            CALC:    if (r_cnt == 5'd1) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.busy   = (r_state == CALC);
    assign bus.done   = (r_state == DONE);
    assign bus.result = r_result;
    assign bus.ovf    = r_ovf;
endmodule

// File: tb/tb_udiv8_seq.sv
// Directed bench for udiv8_seq: reset, both lane modes, overflow/div-by-zero edges, invalid mode, ignored start, mid-op reset.
module tb_udiv8_seq;
    localparam logic [1:0] M8  = 2'd1;
    localparam logic [1:0] M16 = 2'd2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    udiv8_seq_if bus();
    udiv8_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad   = 0;
    int lat, bcnt;

    localparam logic [0:127] A8  = {16'h03E8, 112'h0};
    localparam logic [0:127] B8  = {16'h0700, {7{16'h0100}}};
    localparam logic [0:127] E8  = {16'h8E06, 112'h0};
    localparam logic [0:127] A16 = {32'h0012_3456, 32'h0, 32'h0001_0000, 32'h0};
    localparam logic [0:127] B16 = {32'h0100_0000, 32'h0001_0000, 32'h0003_0000, 32'h0001_0000};
    localparam logic [0:127] E16 = {32'h1234_0056, 32'h0, 32'h5555_0001, 32'h0};

    // lat_o = index of the edge after which done is first seen, E0 (start sampled) = 0; -1 on timeout.
    task automatic run_op(input logic [1:0] mode, input logic [0:127] a, input logic [0:127] b,
                          input int poke, output int lat_o, output int busy_o);
        lat_o  = -1;
        busy_o = 0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.ctrl_ww = mode; bus.reg_A = a; bus.reg_B = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.ctrl_ww = ~mode; bus.reg_A = ~a; bus.reg_B = ~b;
        for (int e = 0; e < 40; e++) begin
            if (e > 0) begin @(posedge clk); #1; end
            bus.start = 1'b0;
            if (e == poke) begin
                bus.start = 1'b1; bus.ctrl_ww = M16;
                bus.reg_A = {128{1'b1}}; bus.reg_B = {8{16'h0100}};
            end
            if (bus.busy) busy_o++;
            if (bus.done) begin lat_o = e; break; end
        end
    endtask

    task automatic test_reset();
        #1;
        total++; if (bus.result !== 128'h0) begin bad++; $display("FAIL reset_result got=%h want=0", bus.result); end
        total++; if (bus.ovf !== 8'h00) begin bad++; $display("FAIL reset_ovf got=%b want=0", bus.ovf); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
`ifdef UDIV_DZ_FLAG_EN
        total++; if (bus.dz !== 8'h00) begin bad++; $display("FAIL reset_dz got=%b want=0", bus.dz); end
`endif
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_div8();
        run_op(M8, A8, B8, -1, lat, bcnt);
        total++; if (lat !== 8) begin bad++; $display("FAIL div8_latency got=%0d want=8", lat); end
        total++; if (bcnt !== 8) begin bad++; $display("FAIL div8_busy_cycles got=%0d want=8", bcnt); end
        total++; if (bus.result !== E8) begin bad++; $display("FAIL div8_result got=%h want=%h", bus.result, E8); end
        total++; if (bus.ovf !== 8'h00) begin bad++; $display("FAIL div8_ovf got=%b want=0", bus.ovf); end
        repeat (5) @(posedge clk); #1;
        total++; if (bus.result !== E8) begin bad++; $display("FAIL div8_hold got=%h want=%h", bus.result, E8); end
    endtask

    task automatic test_div16();
        run_op(M16, A16, B16, -1, lat, bcnt);
        total++; if (lat !== 16) begin bad++; $display("FAIL div16_latency got=%0d want=16", lat); end
        total++; if (bcnt !== 16) begin bad++; $display("FAIL div16_busy_cycles got=%0d want=16", bcnt); end
        total++; if (bus.result !== E16) begin bad++; $display("FAIL div16_result got=%h want=%h", bus.result, E16); end
        total++; if (bus.ovf !== 8'h00) begin bad++; $display("FAIL div16_ovf got=%b want=0", bus.ovf); end
    endtask

    task automatic test_boundary8();
        logic [0:127] a, b, e;
        a = {16'hFEFF, 16'h0A00, 16'h1234, 16'h03E8, 16'h00FF, 16'h7FFF, 16'h0000, 16'h0000};
        b = {16'hFF00, 16'h0A00, 16'h0000, 16'h0700, 16'h1000, 16'h8000, 16'h0100, 16'h0100};
        e = {16'hFFFE, 16'hFFFF, 16'hFFFF, 16'h8E06, 16'h0F0F, 16'hFF7F, 16'h0000, 16'h0000};
        run_op(M8, a, b, -1, lat, bcnt);
        total++; if (lat !== 8) begin bad++; $display("FAIL bnd8_latency got=%0d want=8", lat); end
        total++; if (bus.result !== e) begin bad++; $display("FAIL bnd8_result got=%h want=%h", bus.result, e); end
        total++; if (bus.ovf !== 8'b0110_0000) begin bad++; $display("FAIL bnd8_ovf got=%b want=01100000", bus.ovf); end
`ifdef UDIV_DZ_FLAG_EN
        total++; if (bus.dz !== 8'b0010_0000) begin bad++; $display("FAIL bnd8_dz got=%b want=00100000", bus.dz); end
`endif
    endtask

    task automatic test_overflow16();
        logic [0:127] a, b, e;
        a = {32'h0005_0000, 32'h0, 32'h0, 32'h0};
        b = {32'h0005_0000, 32'h0000_0000, 32'h0001_0000, 32'h0001_0000};
        e = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0};
        run_op(M16, a, b, -1, lat, bcnt);
        total++; if (bus.result !== e) begin bad++; $display("FAIL ovf16_result got=%h want=%h", bus.result, e); end
        total++; if (bus.ovf !== 8'b1100_0000) begin bad++; $display("FAIL ovf16_ovf got=%b want=11000000", bus.ovf); end
`ifdef UDIV_DZ_FLAG_EN
        total++; if (bus.dz !== 8'b0100_0000) begin bad++; $display("FAIL ovf16_dz got=%b want=01000000", bus.dz); end
`endif
    endtask

    // Invalid modes go straight to DONE on the start edge, so done is seen right after E0.
    task automatic test_invalid();
        logic [1:0] codes [0:1];
        codes[0] = 2'd0;
        codes[1] = 2'd3;
        for (int i = 0; i < 2; i++) begin
            run_op(codes[i], A8, B8, -1, lat, bcnt);
            total++; if (lat !== 0) begin bad++; $display("FAIL inv%0d_latency got=%0d want=0", i, lat); end
            total++; if (bcnt !== 0) begin bad++; $display("FAIL inv%0d_busy got=%0d want=0", i, bcnt); end
            total++; if (bus.result !== 128'h0) begin bad++; $display("FAIL inv%0d_result got=%h want=0", i, bus.result); end
            total++; if (bus.ovf !== 8'h00) begin bad++; $display("FAIL inv%0d_ovf got=%b want=0", i, bus.ovf); end
        end
    endtask

    task automatic test_ignore_start();
        int extra;
        run_op(M8, A8, B8, 2, lat, bcnt);
        total++; if (lat !== 8) begin bad++; $display("FAIL ign_latency got=%0d want=8", lat); end
        total++; if (bus.result !== E8) begin bad++; $display("FAIL ign_result got=%h want=%h", bus.result, E8); end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL ign_no_second_op got=%0d want=0", extra); end
    endtask

    task automatic test_reset_mid();
        int extra;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.ctrl_ww = M16; bus.reg_A = A16; bus.reg_B = B16;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++; if (bus.result !== 128'h0) begin bad++; $display("FAIL rstmid_result got=%h want=0", bus.result); end
        total++; if (bus.ovf !== 8'h00) begin bad++; $display("FAIL rstmid_ovf got=%b want=0", bus.ovf); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", bus.busy); end
        @(negedge clk); rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.done) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL rstmid_no_done got=%0d want=0", extra); end
        run_op(M16, A16, B16, -1, lat, bcnt);
        total++; if (lat !== 16) begin bad++; $display("FAIL rstmid_relat got=%0d want=16", lat); end
        total++; if (bus.result !== E16) begin bad++; $display("FAIL rstmid_reresult got=%h want=%h", bus.result, E16); end
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.ctrl_ww = 2'd0;
        bus.reg_A   = '0;
        bus.reg_B   = '0;
        test_reset();
        test_div8();
        test_div16();
        test_boundary8();
        test_overflow16();
        test_invalid();
        test_ignore_start();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
